mlp_weight_reader: RTL and testbench

MLP_WEIGHT_READER -- requirements
Module: mlp_weight_reader

---
 rtl/mlp_weight_reader.sv | 164 ++++++++++++++++
 tb/tb_mlp_weight_reader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_weight_reader.sv
`default_nettype none
// ============================================================================
// Module      : mlp_weight_reader
// Description : Burst reader for an MLP weight memory. On a start request it
//               walks the memory from base_addr for count words (wrapping
//               modulo 2^ADDR_WIDTH) and streams them out through a 2-entry
//               valid/ready FIFO, flagging the final word with out_last and
//               pulsing done once the last word has been handed off.
// Ports       : clk, rst (sync, active-low)
//               start, base_addr, count        - burst request
//               mem_addr, mem_req, mem_rd_data - weight memory (async read)
//               out_data, out_valid, out_ready, out_last - output stream
//               busy, done                     - status
// Revision    : 1.0 - initial release
// ============================================================================
module mlp_weight_reader #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_req,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = ADDR_WIDTH + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  req_q, req_d;
    logic [CW-1:0]         rem_q, rem_d;      // words still to be fetched
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [1:0]            occ_q, occ_d;      // FIFO occupancy, 0..2
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic                  fifo_last_q [2];

    logic w_pop;
    logic w_push;

    assign w_pop  = (occ_q != 2'd0) && out_ready;
    // A full FIFO may still accept a word when a beat frees a slot this cycle,
    // which is what keeps the stream at one word per cycle.
    assign w_push = (state_q == S_FETCH) && (rem_q != '0) &&
                    ((occ_q != 2'd2) || w_pop);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        req_d    = req_q;
        rem_d    = rem_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        wr_ptr_d = wr_ptr_q ^ w_push;
        rd_ptr_d = rd_ptr_q ^ w_pop;
        occ_d    = occ_q;

        case ({w_push, w_pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        state_d = S_FETCH;
                        addr_d  = base_addr;
                        req_d   = 1'b1;
                        busy_d  = 1'b1;
                        rem_d   = count;
                    end else begin
                        // Empty burst: nothing to stream, just acknowledge.
                        done_d = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                if (w_push) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    rem_d  = rem_q - CW'(1);
                    if (rem_q == CW'(1)) begin
                        req_d   = 1'b0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // All words are captured; the burst ends when the final
                // remaining FIFO entry is handed off.
                if (w_pop && (occ_q == 2'd1)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            req_q          <= 1'b0;
            rem_q          <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            occ_q          <= 2'd0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_last_q[0] <= 1'b0;
            fifo_last_q[1] <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            req_q    <= req_d;
            rem_q    <= rem_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            occ_q    <= occ_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (w_push) begin
                fifo_data_q[wr_ptr_q] <= mem_rd_data;
                fifo_last_q[wr_ptr_q] <= (rem_q == CW'(1));
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_req   = req_q;
    assign out_valid = (occ_q != 2'd0);
    assign out_data  = fifo_data_q[rd_ptr_q];
    // Stale entries keep their last flag, so qualify it with valid.
    assign out_last  = out_valid && fifo_last_q[rd_ptr_q];
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mlp_weight_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mlp_weight_reader
// Description : Scoreboard bench for mlp_weight_reader. Each accepted burst
//               pushes its expected word stream into a queue; an independent
//               monitor pops and compares on every output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mlp_weight_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  base_addr;
    logic [2:0]  count;
    logic [1:0]  mem_addr;
    logic        mem_req;
    logic [15:0] mem_rd_data;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [15:0] mem [4];
    logic [16:0] exp_q [$];          // {last, data}

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rmode    = 0;                // 0: always ready, 1: random, 2: pattern
    int pat_idx  = 0;
    int first_beat_cyc = -1;
    bit first_pending  = 0;

    mlp_weight_reader #(.ADDR_WIDTH(2), .DATA_WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .count      (count),
        .mem_addr   (mem_addr),
        .mem_req    (mem_req),
        .mem_rd_data(mem_rd_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rd_data = mem[mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Consumer: drives out_ready just after each rising edge.
    always @(posedge clk) begin
        bit pat [6];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        #1;
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom % 2);
            default: begin
                out_ready = pat[pat_idx];
                pat_idx   = (pat_idx + 1) % 6;
            end
        endcase
    end

    // Monitor: compares every handshake and checks stall stability.
    bit          prev_stall = 0;
    bit          prev_rst   = 0;
    logic [15:0] prev_data;
    logic        prev_last;
    always @(negedge clk) begin
        logic [16:0] e;
        if (rst) begin
            if (prev_stall && prev_rst) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_data", {16'd0, out_data}, {16'd0, prev_data});
                chk("stall_last", {31'd0, out_last}, {31'd0, prev_last});
            end
            if (out_valid && out_ready) begin
                if (first_pending) begin
                    first_beat_cyc = cyc;
                    first_pending  = 0;
                end
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {16'd0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", {16'd0, out_data}, {16'd0, e[15:0]});
                    chk("beat_last", {31'd0, out_last}, {31'd0, e[16]});
                end
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_rst   = rst;
        prev_data  = out_data;
        prev_last  = out_last;
    end

    // Issues one burst starting in the current cycle and waits for done.
    // Returns in the done cycle, so a following call starts back-to-back.
    task automatic run_burst(input int base, input int cnt, input int mode, input bit dup_start);
        int t;
        int d;
        rmode = mode;
        for (int i = 0; i < cnt; i++)
            exp_q.push_back({(i == cnt - 1), mem[(base + i) % 4]});
        first_pending = (cnt > 0);
        start     = 1'b1;
        base_addr = 2'(base);
        count     = 3'(cnt);
        t = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        if (cnt == 0) begin
            chk("zero_done", {31'd0, done}, 32'd1);
            chk("zero_busy", {31'd0, busy}, 32'd0);
            chk("zero_valid", {31'd0, out_valid}, 32'd0);
            return;
        end
        chk("t1_mem_addr", {30'd0, mem_addr}, 32'(base));
        chk("t1_mem_req", {31'd0, mem_req}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        if (dup_start) begin
            @(posedge clk); #1;
            start     = 1'b1;
            base_addr = 2'(base + 2);
            count     = 3'(cnt - 1);
            @(posedge clk); #1;
            start = 1'b0;
        end
        d = 0;
        while (!done && d < 300) begin
            @(posedge clk); #1;
            d++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_queue_empty", 32'(exp_q.size()), 32'd0);
        if (mode == 0) begin
            chk("first_beat_cycle", 32'(first_beat_cyc), 32'(t + 2));
            chk("done_cycle", 32'(cyc), 32'(t + cnt + 2));
        end
        exp_q.delete();
    endtask

    initial begin
        int t;
        int dcount;
        mem[0] = 16'h0011; mem[1] = 16'h0022; mem[2] = 16'h0033; mem[3] = 16'h0044;
        rst = 1'b0; start = 1'b0; base_addr = '0; count = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_addr", {30'd0, mem_addr}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed scenarios.
        run_burst(1, 3, 0, 0);
        run_burst(3, 4, 0, 0);        // address wrap 3,0,1,2
        run_burst(0, 4, 2, 0);        // stalled consumer
        run_burst(0, 0, 0, 0);        // empty burst
        run_burst(2, 4, 0, 1);        // start ignored mid-burst
        run_burst(1, 7, 1, 0);        // count beyond memory depth

        // Reset after the second beat of a 4-word burst; start during reset
        // must lose to reset.
        rmode = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), mem[i]});
        start = 1'b1; base_addr = 2'd0; count = 3'd4;
        t = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < t + 4) begin @(posedge clk); #1; end
        chk("pre_rst_queue", 32'(exp_q.size()), 32'd2);
        rst = 1'b0; start = 1'b1; base_addr = 2'd2; count = 3'd3;
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0;
        exp_q.delete();
        chk("midrst_mem_addr", {30'd0, mem_addr}, 32'd0);
        chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out_data", {16'd0, out_data}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        dcount = 0;
        for (int i = 0; i < 6; i++) begin
            if (done || out_valid || busy) dcount++;
            @(posedge clk); #1;
        end
        chk("midrst_quiet", 32'(dcount), 32'd0);
        run_burst(2, 3, 0, 0);

        // Randomized bursts, issued back-to-back.
        for (int n = 0; n < 30; n++)
            run_burst(int'($urandom % 4), int'($urandom % 8), int'($urandom % 3), 0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
